// File: rtl/alu_pkg.sv
// Shared ALU encodings, RV32 opcode/funct3 constants and the issue-slot entry type.
package alu_pkg;

   localparam int XLEN_C = 32;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_XOR = 4'b0011;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   typedef struct packed {
      logic [XLEN_C-1:0] data1;
      logic [XLEN_C-1:0] data2;
      logic [3:0]        alu_control;
      logic              illegal;
   } issue_entry_t;

   localparam issue_entry_t ENTRY_ZERO = '0;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32 ALU op decoder; shared with the branch unit.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [3:0] alu_control,
   output logic       use_imm,
   output logic       illegal
);

   // Unsupported encodings fall through to AND (0000) with illegal set.
   always_comb begin
      alu_control = ALU_AND;
      use_imm     = 1'b0;
      illegal     = 1'b0;
      unique case (opcode)
         OP_R, OP_I: begin
            use_imm = (opcode == OP_I);
            case (funct3)
               F3_ADD:  alu_control = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
               F3_XOR:  alu_control = ALU_XOR;
               F3_OR:   alu_control = ALU_OR;
               F3_AND:  alu_control = ALU_AND;
               default: illegal     = 1'b1;
            endcase
         end
         OP_LOAD, OP_STORE: begin
            alu_control = ALU_ADD;
            use_imm     = 1'b1;
         end
         OP_BRANCH: alu_control = ALU_SUB;
         default:   illegal     = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue.sv
// ALU issue slot: decodes operands/op and hands them to execute through a
// registered output stage backed by a one-entry skid register.
//
// state | meaning
// EMPTY | nothing buffered, out_valid=0
// ONE   | output register holds an op
// FULL  | output and skid both hold ops, in_ready=0
module alu_issue
   import alu_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter bit ILLEGAL_AS_NOP = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct3,
   input  logic            funct7_5,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] data1,
   output logic [XLEN-1:0] data2,
   output logic [3:0]      alu_control,
   output logic            illegal,
   output logic            illegal_pulse
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } issue_state_e;

   issue_state_e state_q, state_d;
   issue_entry_t out_q, out_d;
   issue_entry_t skid_q, skid_d;
   logic         in_ready_q, in_ready_d;
   logic         illegal_pulse_q, illegal_pulse_d;

   logic [3:0]   dec_alu_control;
   logic         dec_use_imm;
   logic         dec_illegal;
   issue_entry_t new_entry;
   logic         accept;
   logic         push;
   logic         pop;

   alu_op_decode u_decode (
      .opcode      (opcode),
      .funct3      (funct3),
      .funct7_5    (funct7_5),
      .alu_control (dec_alu_control),
      .use_imm     (dec_use_imm),
      .illegal     (dec_illegal)
   );

   // Build the candidate entry and the accept/push/pop strobes.
   always_comb begin
      new_entry.data1       = rs1_data;
      new_entry.data2       = dec_use_imm ? imm : rs2_data;
      new_entry.alu_control = dec_illegal ? ALU_AND : dec_alu_control;
      new_entry.illegal     = dec_illegal;
      accept = in_valid && in_ready_q && !flush;
      // Dropped illegal ops are still accepted (and pulsed) but never stored.
      push   = accept && (!dec_illegal || ILLEGAL_AS_NOP);
      pop    = (state_q != ST_EMPTY) && out_ready;
   end

   // Next-state, buffer moves and the registered ready/pulse outputs.
   always_comb begin
      state_d         = state_q;
      out_d           = out_q;
      skid_d          = skid_q;
      illegal_pulse_d = accept && dec_illegal;
      unique case (state_q)
         ST_EMPTY: begin
            if (push) begin
               out_d   = new_entry;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (push && pop) begin
               out_d = new_entry;
            end else if (push) begin
               skid_d  = new_entry;
               state_d = ST_FULL;
            end else if (pop) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (pop) begin
               out_d   = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush) begin
         state_d = ST_EMPTY;
      end
      in_ready_d = (state_d != ST_FULL);
   end

   // State and data registers; reset also clears data for deterministic sims.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_EMPTY;
         out_q           <= ENTRY_ZERO;
         skid_q          <= ENTRY_ZERO;
         in_ready_q      <= 1'b1;
         illegal_pulse_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         out_q           <= out_d;
         skid_q          <= skid_d;
         in_ready_q      <= in_ready_d;
         illegal_pulse_q <= illegal_pulse_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = (state_q != ST_EMPTY);
   assign data1         = out_q.data1;
   assign data2         = out_q.data2;
   assign alu_control   = out_q.alu_control;
   assign illegal       = out_q.illegal;
   assign illegal_pulse = illegal_pulse_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue; a second instance covers the drop-illegal build.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, funct7_5, out_ready;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] rs1_data, rs2_data, imm;

   logic        in_ready, out_valid, illegal, illegal_pulse;
   logic [31:0] data1, data2;
   logic [3:0]  alu_control;

   logic        d_in_ready, d_out_valid, d_illegal, d_illegal_pulse;
   logic [31:0] d_data1, d_data2;
   logic [3:0]  d_alu_control;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_issue #(.XLEN(32), .ILLEGAL_AS_NOP(1'b1)) u_dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .data1(data1), .data2(data2),
      .alu_control(alu_control), .illegal(illegal), .illegal_pulse(illegal_pulse)
   );

   alu_issue #(.XLEN(32), .ILLEGAL_AS_NOP(1'b0)) u_dut_drop (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d_in_ready),
      .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
      .out_valid(d_out_valid), .out_ready(out_ready), .data1(d_data1), .data2(d_data2),
      .alu_control(d_alu_control), .illegal(d_illegal), .illegal_pulse(d_illegal_pulse)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
      in_valid = 1'b1;
      opcode   = op;
      funct3   = f3;
      funct7_5 = f75;
      rs1_data = r1;
      rs2_data = r2;
      imm      = im;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      opcode = '0; funct3 = '0; funct7_5 = 1'b0;
      rs1_data = '0; rs2_data = '0; imm = '0;
      tick(); tick();
      reset = 1'b0;
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_in_ready", in_ready, 1);
      check_val("rst_data1", data1, 0);
      check_val("rst_data2", data2, 0);
      check_val("rst_alu_control", alu_control, 0);
      check_val("rst_illegal", illegal, 0);
      check_val("rst_pulse", illegal_pulse, 0);

      // R-type SUB
      out_ready = 1'b1;
      drive(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'd99);
      tick();
      in_valid = 1'b0;
      check_val("sub_valid", out_valid, 1);
      check_val("sub_ctrl", alu_control, 4'b0110);
      check_val("sub_data1", data1, 10);
      check_val("sub_data2", data2, 3);
      check_val("sub_illegal", illegal, 0);
      tick();
      check_val("sub_drained", out_valid, 0);

      // ADDI with funct7_5 set stays ADD and uses the immediate
      drive(7'b0010011, 3'b000, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFF);
      tick();
      in_valid = 1'b0;
      check_val("addi_ctrl", alu_control, 4'b0010);
      check_val("addi_data1", data1, 5);
      check_val("addi_data2", data2, 32'hFFFF_FFFF);

      // Store -> ADD with imm; branch -> SUB with rs2
      drive(7'b0100011, 3'b010, 1'b0, 32'h100, 32'h55, 32'h8);
      tick();
      check_val("store_ctrl", alu_control, 4'b0010);
      check_val("store_data2", data2, 32'h8);
      drive(7'b1100011, 3'b001, 1'b0, 32'h20, 32'h21, 32'h40);
      tick();
      in_valid = 1'b0;
      check_val("branch_ctrl", alu_control, 4'b0110);
      check_val("branch_data2", data2, 32'h21);
      check_val("branch_illegal", illegal, 0);
      tick();

      // Backpressure: XOR then OR fills both entries
      out_ready = 1'b0;
      drive(7'b0110011, 3'b100, 1'b0, 32'hA, 32'h5, 32'h0);
      tick();
      check_val("bp_one_ready", in_ready, 1);
      drive(7'b0110011, 3'b110, 1'b0, 32'hC, 32'h3, 32'h0);
      tick();
      in_valid = 1'b0;
      check_val("bp_full_ready", in_ready, 0);
      check_val("bp_full_ctrl", alu_control, 4'b0011);
      tick();
      check_val("bp_hold_ctrl", alu_control, 4'b0011);
      check_val("bp_hold_data1", data1, 32'hA);
      check_val("bp_hold_valid", out_valid, 1);
      out_ready = 1'b1;
      tick();
      check_val("bp_second_ctrl", alu_control, 4'b0001);
      check_val("bp_second_data1", data1, 32'hC);
      check_val("bp_second_valid", out_valid, 1);
      check_val("bp_ready_again", in_ready, 1);
      tick();
      check_val("bp_drained", out_valid, 0);

      // Unsupported R-type funct3=001 on both builds
      drive(7'b0110011, 3'b001, 1'b0, 32'h11, 32'h22, 32'h0);
      tick();
      in_valid = 1'b0;
      check_val("ill_pulse", illegal_pulse, 1);
      check_val("ill_valid", out_valid, 1);
      check_val("ill_ctrl", alu_control, 4'b0000);
      check_val("ill_flag", illegal, 1);
      check_val("drop_pulse", d_illegal_pulse, 1);
      check_val("drop_valid", d_out_valid, 0);
      tick();
      check_val("ill_pulse_end", illegal_pulse, 0);
      check_val("drop_still_empty", d_out_valid, 0);

      // Unsupported opcode (LUI) also flagged
      drive(7'b0110111, 3'b000, 1'b0, 32'h1, 32'h2, 32'h3);
      tick();
      in_valid = 1'b0;
      check_val("lui_flag", illegal, 1);
      check_val("lui_pulse", illegal_pulse, 1);
      tick();

      // Flush in FULL with a simultaneous input
      out_ready = 1'b0;
      drive(7'b0110011, 3'b000, 1'b0, 32'h1, 32'h1, 32'h0);
      tick();
      drive(7'b0110011, 3'b111, 1'b0, 32'h2, 32'h2, 32'h0);
      tick();
      check_val("fl_full", in_ready, 0);
      drive(7'b0110011, 3'b100, 1'b0, 32'h3, 32'h3, 32'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check_val("fl_valid", out_valid, 0);
      check_val("fl_ready", in_ready, 1);
      out_ready = 1'b1;
      tick();
      check_val("fl_no_ghost1", out_valid, 0);
      tick();
      check_val("fl_no_ghost2", out_valid, 0);

      // Flush in the accept cycle of an illegal op suppresses the pulse
      drive(7'b0110011, 3'b010, 1'b0, 32'h0, 32'h0, 32'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check_val("fl_ill_pulse", illegal_pulse, 0);
      check_val("fl_ill_valid", out_valid, 0);
      check_val("fl_ill_drop_pulse", d_illegal_pulse, 0);

      // Reset mid-stream in FULL
      out_ready = 1'b0;
      drive(7'b0110011, 3'b000, 1'b1, 32'h9, 32'h4, 32'h0);
      tick();
      drive(7'b0110011, 3'b110, 1'b0, 32'h6, 32'h1, 32'h0);
      tick();
      in_valid = 1'b0;
      check_val("rs_full", in_ready, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_val("rs_valid", out_valid, 0);
      check_val("rs_ready", in_ready, 1);
      check_val("rs_data1", data1, 0);
      check_val("rs_data2", data2, 0);
      check_val("rs_ctrl", alu_control, 0);
      out_ready = 1'b1;
      drive(7'b0110011, 3'b000, 1'b0, 32'd7, 32'd8, 32'h0);
      tick();
      in_valid = 1'b0;
      check_val("rs_add_valid", out_valid, 1);
      check_val("rs_add_ctrl", alu_control, 4'b0010);
      check_val("rs_add_data1", data1, 7);
      check_val("rs_add_data2", data2, 8);
      tick();
      check_val("rs_add_drained", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
